// File: rtl/rcos_pkg.sv
// rcos_pkg: default raised-cosine coefficients, accumulator sizing and round/saturate helpers.
package rcos_pkg;
  localparam int RCOS_COEF_DEFAULT [5] = '{'h26, 'h36, 'h44, 'h50, 'h51};
  function automatic int acc_width(int dsize, int csize, int nuniq);
    return dsize + 1 + csize + $clog2(nuniq);
  endfunction
  // Indexed from the centre outward so larger NTAP reuses the 9-tap shape, padded with the outer value.
  function automatic int coef_default(int nuniq, int i);
    int j;
    j = nuniq - 1 - i;
    return j < 5 ? RCOS_COEF_DEFAULT[4 - j] : RCOS_COEF_DEFAULT[0];
  endfunction
  function automatic logic signed [63:0] round_shift(logic signed [63:0] v, int sh);
    logic signed [63:0] b;
    b = sh > 0 ? 64'sd1 <<< (sh - 1) : 64'sd0;
    return (v + b) >>> sh;
  endfunction
  function automatic logic signed [63:0] sat_max(int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction
endpackage

// File: rtl/rcos_fir_sym_pipe_add_tree.sv
// rcos_add_tree: exact signed sum of N products into OW bits, registered (stage 3).
module rcos_add_tree #(
  parameter int N  = 5,
  parameter int W  = 17,
  parameter int OW = 20
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clr,
  input  logic signed [W-1:0]  din [N],
  output logic signed [OW-1:0] sum
);
  logic signed [OW-1:0] s;
  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++) s = s + OW'(din[i]);
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) sum <= '0;
    else sum <= clr ? '0 : s;
endmodule

// File: rtl/rcos_fir_sym_pipe.sv
// rcos_fir_sym_pipe: pipelined symmetric raised-cosine FIR with rounding and saturation.
// Define RCOS_COEF_LOAD_EN for a run-time writable coefficient bank.
module rcos_fir_sym_pipe import rcos_pkg::*; #(
  parameter int DSIZE  = 8,
  parameter int CSIZE  = 8,
  parameter int NTAP   = 9,
  parameter int OSHIFT = 0,
  parameter int OSIZE  = 19
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic [DSIZE-1:0]              din,
`ifdef RCOS_COEF_LOAD_EN
  input  logic                          coef_we,
  input  logic [$clog2((NTAP+1)/2)-1:0] coef_addr,
  input  logic [CSIZE-1:0]              coef_wdata,
`endif
  output logic                          out_valid,
  output logic [OSIZE-1:0]              dout,
  output logic                          sat_flag
);
  localparam int NUNIQ = (NTAP + 1) / 2;
  localparam int AW    = DSIZE + 1;
  localparam int PW    = AW + CSIZE;
  localparam int ACC_W = acc_width(DSIZE, CSIZE, NUNIQ);
  localparam logic signed [63:0] SMAX = sat_max(OSIZE);
  localparam logic signed [63:0] SMIN = -SMAX - 64'sd1;
  logic signed [DSIZE-1:0] d [NTAP-1];
  logic signed [DSIZE-1:0] x [NTAP];
  logic signed [CSIZE-1:0] coef [NUNIQ];
  logic signed [AW-1:0]    a [NUNIQ];
  logic signed [AW-1:0]    a_q [NUNIQ];
  logic signed [PW-1:0]    p_q [NUNIQ];
  logic signed [ACC_W-1:0] sum_q;
  logic signed [63:0]      r;
  logic [3:1]              v;
  assign x[0] = $signed(din);
  for (genvar j = 1; j < NTAP; j++) begin : g_x
    assign x[j] = d[j-1];
  end
`ifdef RCOS_COEF_LOAD_EN
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) for (int i = 0; i < NUNIQ; i++) coef[i] <= CSIZE'(coef_default(NUNIQ, i));
    else if (coef_we) for (int i = 0; i < NUNIQ; i++) if (int'(coef_addr) == i) coef[i] <= $signed(coef_wdata);
`else
  for (genvar i = 0; i < NUNIQ; i++) begin : g_coef
    assign coef[i] = CSIZE'(coef_default(NUNIQ, i));
  end
`endif
  // Idle cycles hold the delay line so gaps in in_valid never inject zeros.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) for (int i = 0; i < NTAP - 1; i++) d[i] <= '0;
    else if (clr) for (int i = 0; i < NTAP - 1; i++) d[i] <= '0;
    else if (in_valid) begin
      d[0] <= $signed(din);
      for (int i = 1; i < NTAP - 1; i++) d[i] <= d[i-1];
    end
  always_comb begin
    for (int i = 0; i < NUNIQ - 1; i++) a[i] = AW'(x[i]) + AW'(x[NTAP-1-i]);
    a[NUNIQ-1] = AW'(x[NUNIQ-1]);
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst || clr) begin
      for (int i = 0; i < NUNIQ; i++) a_q[i] <= '0;
      for (int i = 0; i < NUNIQ; i++) p_q[i] <= '0;
      v <= '0;
    end else begin
      a_q <= a;
      for (int i = 0; i < NUNIQ; i++) p_q[i] <= PW'(a_q[i]) * PW'(coef[i]);
      v <= {v[2:1], in_valid};
    end
  rcos_add_tree #(.N(NUNIQ), .W(PW), .OW(ACC_W)) u_tree (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (clr),
    .din   (p_q),
    .sum   (sum_q)
  );
  assign r = round_shift(64'(sum_q), OSHIFT);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst || clr) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= v[3];
      sat_flag  <= v[3] && (r > SMAX || r < SMIN);
      if (v[3]) dout <= r > SMAX ? SMAX[OSIZE-1:0] : r < SMIN ? SMIN[OSIZE-1:0] : r[OSIZE-1:0];
    end
endmodule
